hwpe_test_ctrl: RTL
===================

Name: hwpe_test_ctrl

Overview:
- Job sequencer for the load/store streamer datapath: one source (load) streamer, one sink (store) streamer, their FIFOs.
- Takes a configured job (src/dst base, length, repetitions) and drives both streamers' ctrl structs.
- Starts each repetition on a handshake, tracks per-streamer completion, advances addresses between repetitions, signals job end.
- Sits between the register file/peripheral slave and the streamer datapath.

Parameters:
DATA_WIDTH, 32, streamed word width in bits; byte step per word = DATA_WIDTH/8
ADDR_WIDTH, 32, TCDM byte address width
LEN_WIDTH, 16, word-count width of one repetition
REPS_WIDTH, 8, repetition-count width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  synchronous soft clear, same effect as reset
start_i  in  1  job start pulse; sampled only in IDLE
cfg_src_addr_i  in  ADDR_WIDTH  source base byte address
cfg_dst_addr_i  in  ADDR_WIDTH  sink base byte address
cfg_len_i  in  LEN_WIDTH  words per repetition
cfg_reps_i  in  REPS_WIDTH  repetitions; 0 treated as 1
source_stream_ctrl_o  out  ctrl_sourcesink_t  source streamer control
source_stream_flags_i  in  flags_sourcesink_t  source streamer flags (ready_start, done)
sink_stream_ctrl_o  out  ctrl_sourcesink_t  sink streamer control
sink_stream_flags_i  in  flags_sourcesink_t  sink streamer flags
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job end
err_o  out  1  sticky: sink done before source; cleared on next accepted start
rep_cnt_o  out  REPS_WIDTH  completed repetitions of current job

Behaviour:
- Reset/clear (sync, rst_ni=0 or clear_i=1 at posedge): state IDLE; all ctrl fields 0; busy_o=0, done_o=0, err_o=0, rep_cnt_o=0; sticky done bits 0. Clear mid-job abandons the job without a done pulse.
- Config latched on accepted start_i (IDLE and start_i=1); later config changes ignored until next job. start_i outside IDLE ignored.
- States:
  - IDLE: on start with cfg_len_i=0 -> DONE directly (no req_start issued); otherwise -> WAIT_RDY, busy_o=1.
  - WAIT_RDY: when source.ready_start and sink.ready_start both 1 in the same cycle -> START.
  - START: exactly one cycle of req_start=1 on both ctrls -> BUSY. Address fields valid from WAIT_RDY entry and held stable through BUSY.
  - BUSY: sticky src_done/snk_done set on the respective flags.done pulse (simultaneous pulses handled). Sink done with src_done still 0 and no source done in the same cycle -> err_o=1, job continues. When both sticky bits set: rep_cnt+1 and clear sticky bits; if rep_cnt+1 == reps -> DONE, else advance both base addresses by len*DATA_WIDTH/8 (mod 2^ADDR_WIDTH wrap) and -> WAIT_RDY.
  - DONE: done_o=1 for one cycle, busy_o=0 -> IDLE. rep_cnt_o holds until next start.
- Ctrl mapping, both streamers: addressgen_ctrl.base_addr = current base; trans_size = len; line_stride = DATA_WIDTH/8; line_length = len; feat_stride=0; feat_length=1; feat_roll=0; loop_outer=0; realign_type=0. All other fields 0.
- Latency: accepted start with both streamers ready -> req_start 2 cycles later (WAIT_RDY, START). Last done -> done_o 2 cycles later (BUSY update, DONE).
- Address step computed at LEN_WIDTH+log2(bytes) bits, truncated to ADDR_WIDTH.

Decomposition:
- Package hwpe_test_ctrl_pkg: state enum (IDLE, WAIT_RDY, START, BUSY, DONE), BYTES_PER_WORD constant, job-config packed struct (src, dst, len, reps).
- ctrl_sourcesink_t / flags_sourcesink_t come from the existing stream package.
- One sub-module, hwpe_test_ctrl_addrgen: holds both base-address registers; load on start, step on rep advance.

Test Plan:
- src=0x1000, dst=0x2000, len=16, reps=1, streamers ready; source done cycle 40, sink done cycle 50 -> one req_start each with base 0x1000/0x2000, trans_size=16; done_o pulse 2 cycles after sink done; rep_cnt_o=1; err_o=0.
- reps=3, len=8 -> three req_start pulses; bases 0x1000/0x1020/0x1040 and 0x2000/0x2020/0x2040; single done_o after third pair; rep_cnt_o=3.
- len=0 -> no req_start, done_o 1 cycle after start, busy_o high exactly 1 cycle.
- sink ready_start held 0 for 20 cycles -> stays WAIT_RDY, no req_start; first cycle with both ready -> req_start next cycle. Second start_i pulse in BUSY -> ignored.
- Sink done pulse before source done -> err_o=1, job still completes with done_o; next start clears err_o. Simultaneous source/sink done -> err_o=0, rep counted once.
- clear_i in BUSY mid-repetition -> next cycle IDLE, all ctrl 0, busy_o=0, no done_o; new start runs normally. src=0xFFFFFFF0, len=8, reps=2 -> second base 0x00000010 (wrap).

Source files
------------

// File: rtl/hwpe_stream_package.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_package
// Description : Streamer control/flag types shared by the load/store
//               streamers and the controllers that drive them.
//               ctrl_sourcesink_t   - request + address generator setup
//               flags_sourcesink_t  - ready_start / done status from a streamer
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_stream_package;

   typedef struct packed {
      logic [31:0] base_addr;
      logic [31:0] trans_size;
      logic [15:0] line_stride;
      logic [15:0] line_length;
      logic [15:0] feat_stride;
      logic [15:0] feat_length;
      logic        loop_outer;
      logic [15:0] feat_roll;
      logic        realign_type;
      logic [7:0]  line_length_remainder;
   } ctrl_addressgen_t;

   typedef struct packed {
      logic             req_start;
      ctrl_addressgen_t addressgen_ctrl;
   } ctrl_sourcesink_t;

   typedef struct packed {
      logic ready_start;
      logic done;
   } flags_sourcesink_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_test_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_test_ctrl_pkg
// Description : Types and constants of the load/store job sequencer.
//               state_e     - sequencer FSM states
//               job_cfg_t   - one job as seen at the configuration inputs
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_test_ctrl_pkg;

   // Default word geometry; the job struct fields are sized to the default
   // port widths and the top narrows/widens them to its own parameters.
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned JOB_ADDR_WIDTH = 32;
   localparam int unsigned JOB_LEN_WIDTH  = 16;
   localparam int unsigned JOB_REPS_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_RDY = 3'd1,
      START    = 3'd2,
      BUSY     = 3'd3,
      DONE     = 3'd4
   } state_e;

   typedef struct packed {
      logic [JOB_ADDR_WIDTH-1:0] src;
      logic [JOB_ADDR_WIDTH-1:0] dst;
      logic [JOB_LEN_WIDTH-1:0]  len;
      logic [JOB_REPS_WIDTH-1:0] reps;
   } job_cfg_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_test_ctrl_addrgen.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_test_ctrl_addrgen
// Description : Source and sink base-address registers of the sequencer.
//               Loaded from the job config on an accepted start, advanced by
//               one repetition stride (modulo 2^ADDR_WIDTH) between reps.
// Ports       : clk_i, rst_ni, clear_i   - clock, sync reset, soft clear
//               load_i, load_src/dst_i   - load both bases
//               step_i, stride_i         - add stride to both bases
//               src_addr_o, dst_addr_o   - current bases
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_test_ctrl_addrgen
   import hwpe_test_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = JOB_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] load_src_i,
   input  logic [ADDR_WIDTH-1:0] load_dst_i,
   input  logic                  step_i,
   input  logic [ADDR_WIDTH-1:0] stride_i,
   output logic [ADDR_WIDTH-1:0] src_addr_o,
   output logic [ADDR_WIDTH-1:0] dst_addr_o
);

   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;

   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      if (load_i) begin
         src_d = load_src_i;
         dst_d = load_dst_i;
      end else if (step_i) begin
         src_d = src_q + stride_i;
         dst_d = dst_q + stride_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         src_q <= '0;
         dst_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
      end
   end

   assign src_addr_o = src_q;
   assign dst_addr_o = dst_q;

endmodule
`default_nettype wire

// File: rtl/hwpe_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_test_ctrl
// Description : Job sequencer for one source and one sink streamer. Runs a
//               configured number of repetitions of a linear transfer,
//               handshaking each repetition start and tracking completion of
//               both streamers.
// Ports       : clk_i, rst_ni, clear_i      - clock, sync reset, soft clear
//               start_i, cfg_*_i            - job start and configuration
//               source/sink_stream_ctrl_o   - streamer control structs
//               source/sink_stream_flags_i  - streamer ready/done flags
//               busy_o, done_o, err_o       - job status
//               rep_cnt_o                   - completed repetitions
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_test_ctrl
   import hwpe_stream_package::*;
   import hwpe_test_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = BYTES_PER_WORD * 8,
   parameter int unsigned ADDR_WIDTH = JOB_ADDR_WIDTH,
   parameter int unsigned LEN_WIDTH  = JOB_LEN_WIDTH,
   parameter int unsigned REPS_WIDTH = JOB_REPS_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] cfg_src_addr_i,
   input  logic [ADDR_WIDTH-1:0] cfg_dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  cfg_len_i,
   input  logic [REPS_WIDTH-1:0] cfg_reps_i,
   output ctrl_sourcesink_t      source_stream_ctrl_o,
   input  flags_sourcesink_t     source_stream_flags_i,
   output ctrl_sourcesink_t      sink_stream_ctrl_o,
   input  flags_sourcesink_t     sink_stream_flags_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [REPS_WIDTH-1:0] rep_cnt_o
);

   localparam int unsigned c_bytes      = DATA_WIDTH / 8;
   // Wide enough for len * bytes without overflow before truncation.
   localparam int unsigned c_step_width = LEN_WIDTH + $clog2(c_bytes);

   state_e                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [REPS_WIDTH-1:0]   reps_q;
   logic [REPS_WIDTH-1:0]   rep_cnt_q;
   logic                    src_done_q;
   logic                    snk_done_q;
   logic                    err_q;

   job_cfg_t                w_cfg;
   logic                    w_accept;
   logic                    w_rep_done;
   logic                    w_rep_advance;
   logic [REPS_WIDTH-1:0]   w_rep_next;
   logic [c_step_width-1:0] w_step_full;
   logic [ADDR_WIDTH-1:0]   w_stride;
   logic [ADDR_WIDTH-1:0]   w_src_addr;
   logic [ADDR_WIDTH-1:0]   w_dst_addr;
   logic                    w_ctrl_valid;
   ctrl_addressgen_t        w_ag_common;

   assign w_cfg.src  = JOB_ADDR_WIDTH'(cfg_src_addr_i);
   assign w_cfg.dst  = JOB_ADDR_WIDTH'(cfg_dst_addr_i);
   assign w_cfg.len  = JOB_LEN_WIDTH'(cfg_len_i);
   assign w_cfg.reps = JOB_REPS_WIDTH'(cfg_reps_i);

   assign w_rep_next  = rep_cnt_q + REPS_WIDTH'(1);
   assign w_step_full = c_step_width'(len_q) * c_step_width'(c_bytes);
   assign w_stride    = ADDR_WIDTH'(w_step_full);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d       = state_q;
      w_accept      = 1'b0;
      w_rep_done    = 1'b0;
      w_rep_advance = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               w_accept = 1'b1;
               // Empty job: no streamer request, finish immediately.
               state_d  = (w_cfg.len == '0) ? DONE : WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (source_stream_flags_i.ready_start && sink_stream_flags_i.ready_start)
               state_d = START;
         end
         START: state_d = BUSY;
         BUSY: begin
            if (src_done_q && snk_done_q) begin
               w_rep_done = 1'b1;
               if (w_rep_next == reps_q) begin
                  state_d = DONE;
               end else begin
                  w_rep_advance = 1'b1;
                  state_d       = WAIT_RDY;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         reps_q     <= '0;
         rep_cnt_q  <= '0;
         src_done_q <= 1'b0;
         snk_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            len_q      <= LEN_WIDTH'(w_cfg.len);
            reps_q     <= (w_cfg.reps == '0) ? REPS_WIDTH'(1) : REPS_WIDTH'(w_cfg.reps);
            rep_cnt_q  <= '0;
            src_done_q <= 1'b0;
            snk_done_q <= 1'b0;
            err_q      <= 1'b0;
         end
         if (state_q == BUSY) begin
            if (w_rep_done) begin
               rep_cnt_q  <= w_rep_next;
               src_done_q <= 1'b0;
               snk_done_q <= 1'b0;
            end else begin
               if (source_stream_flags_i.done) src_done_q <= 1'b1;
               if (sink_stream_flags_i.done)   snk_done_q <= 1'b1;
               // Sink finishing ahead of the source means it drained data
               // the source never produced; flag it but let the job run on.
               if (sink_stream_flags_i.done && !src_done_q && !source_stream_flags_i.done)
                  err_q <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------ base addresses
   hwpe_test_ctrl_addrgen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) i_addrgen (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .load_i     (w_accept),
      .load_src_i (ADDR_WIDTH'(w_cfg.src)),
      .load_dst_i (ADDR_WIDTH'(w_cfg.dst)),
      .step_i     (w_rep_advance),
      .stride_i   (w_stride),
      .src_addr_o (w_src_addr),
      .dst_addr_o (w_dst_addr)
   );

   // ------------------------------------------------------ streamer ctrl
   assign w_ctrl_valid = (state_q == WAIT_RDY) || (state_q == START) || (state_q == BUSY);

   always_comb begin
      w_ag_common             = '0;
      w_ag_common.trans_size  = 32'(len_q);
      w_ag_common.line_stride = 16'(c_bytes);
      w_ag_common.line_length = 16'(len_q);
      w_ag_common.feat_length = 16'd1;
   end

   always_comb begin
      source_stream_ctrl_o = '0;
      sink_stream_ctrl_o   = '0;
      if (w_ctrl_valid) begin
         source_stream_ctrl_o.addressgen_ctrl           = w_ag_common;
         source_stream_ctrl_o.addressgen_ctrl.base_addr = 32'(w_src_addr);
         source_stream_ctrl_o.req_start                 = (state_q == START);
         sink_stream_ctrl_o.addressgen_ctrl             = w_ag_common;
         sink_stream_ctrl_o.addressgen_ctrl.base_addr   = 32'(w_dst_addr);
         sink_stream_ctrl_o.req_start                   = (state_q == START);
      end
   end

   // Busy rises in the cycle the start is accepted so even an empty job
   // shows one busy cycle; it drops in DONE.
   assign busy_o    = w_ctrl_valid || w_accept;
   assign done_o    = (state_q == DONE);
   assign err_o     = err_q;
   assign rep_cnt_o = rep_cnt_q;

endmodule
`default_nettype wire
